// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, 4-bit ALU op codes, pipeline
// state enum and the decode/payload structs used by the ID/EX stage.
package rv_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   // ALU op = {funct7[5], funct3}; SUB and SRA are the only codes with bit 3 set.
   localparam logic [3:0] ALU_ADD  = 4'h0;
   localparam logic [3:0] ALU_SLL  = 4'h1;
   localparam logic [3:0] ALU_SLT  = 4'h2;
   localparam logic [3:0] ALU_SLTU = 4'h3;
   localparam logic [3:0] ALU_XOR  = 4'h4;
   localparam logic [3:0] ALU_SRL  = 4'h5;
   localparam logic [3:0] ALU_OR   = 4'h6;
   localparam logic [3:0] ALU_AND  = 4'h7;
   localparam logic [3:0] ALU_SUB  = 4'h8;
   localparam logic [3:0] ALU_SRA  = 4'hD;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } stage_state_e;

   typedef struct packed {
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [3:0]  alu_op;
      logic        use_imm;
      logic        use_rs1;
      logic        use_rs2;
      logic        reg_write;
      logic        illegal;
   } decode_t;

   typedef struct packed {
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [3:0]  alu_op;
      logic        use_imm;
      logic        reg_write;
      logic        illegal;
   } ex_payload_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bus between fetch/regfile/execute and the ID/EX stage. Handshakes are
// valid/ready: a transfer happens in a cycle where both are high, and a
// producer holding valid keeps its payload stable until ready is seen.
interface id_ex_stage_if;
   import rv_pkg::*;

   logic         in_valid;
   logic         in_ready;
   logic [31:0]  instr;
   logic [4:0]   source_reg1;
   logic [4:0]   source_reg2;
   logic [31:0]  reg1_data;
   logic [31:0]  reg2_data;
   logic         flush;
   logic         wb_reg_write;
   logic [4:0]   wb_rd;
   logic [31:0]  wb_data;
   logic         ex_valid;
   logic         ex_ready;
   logic [31:0]  ex_rs1_val;
   logic [31:0]  ex_rs2_val;
   logic [31:0]  ex_imm;
   logic [4:0]   ex_rd;
   logic [3:0]   ex_alu_op;
   logic         ex_use_imm;
   logic         ex_reg_write;
   logic         ex_illegal;
   stage_state_e dbg_state;

   modport master (
      output in_valid, instr, reg1_data, reg2_data, flush,
             wb_reg_write, wb_rd, wb_data, ex_ready,
      input  in_ready, source_reg1, source_reg2, ex_valid,
             ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_alu_op,
             ex_use_imm, ex_reg_write, ex_illegal, dbg_state
   );

   modport slave (
      input  in_valid, instr, reg1_data, reg2_data, flush,
             wb_reg_write, wb_rd, wb_data, ex_ready,
      output in_ready, source_reg1, source_reg2, ex_valid,
             ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_alu_op,
             ex_use_imm, ex_reg_write, ex_illegal, dbg_state
   );

endinterface

// File: rtl/instr_decoder.sv
// Purely combinational RV32I field and immediate decode for the subset
// handled by the ID/EX stage (R-type ALU, I-type ALU, LUI).
module instr_decoder
   import rv_pkg::*;
(
   input  logic [31:0] instr_i,
   output decode_t     dec_o
);

   logic [6:0] opcode;
   logic [2:0] funct3;

   assign opcode = instr_i[6:0];
   assign funct3 = instr_i[14:12];

   always_comb begin
      dec_o     = '0;
      dec_o.rs1 = instr_i[19:15];
      dec_o.rs2 = instr_i[24:20];
      dec_o.rd  = instr_i[11:7];
      case (opcode)
         OPC_OP: begin
            dec_o.alu_op  = {instr_i[30], funct3};
            dec_o.use_rs1 = 1'b1;
            dec_o.use_rs2 = 1'b1;
         end
         OPC_OP_IMM: begin
            dec_o.imm     = {{20{instr_i[31]}}, instr_i[31:20]};
            // Only the shift-right pair uses funct7[5]; other immediates own that bit.
            dec_o.alu_op  = {(funct3 == 3'b101) ? instr_i[30] : 1'b0, funct3};
            dec_o.use_imm = 1'b1;
            dec_o.use_rs1 = 1'b1;
         end
         OPC_LUI: begin
            dec_o.imm     = {instr_i[31:12], 12'b0};
            dec_o.alu_op  = ALU_ADD;
            dec_o.use_imm = 1'b1;
         end
         default: begin
            dec_o.illegal = 1'b1;
         end
      endcase
      dec_o.reg_write = !dec_o.illegal && (dec_o.rd != 5'd0);
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes one RV32I instruction and holds the
// execute payload. Optional writeback bypass enabled by ID_WB_BYPASS_EN.
module id_ex_stage
   import rv_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   id_ex_stage_if.slave  bus
);

   decode_t      dec;
   stage_state_e state_q, state_d;
   ex_payload_t  payload_q, payload_d;
   logic         ex_valid;
   logic         in_ready;
   logic         capture;
   logic [31:0]  src1_val;
   logic [31:0]  src2_val;

   instr_decoder u_decoder (
      .instr_i (bus.instr),
      .dec_o   (dec)
   );

`ifdef ID_WB_BYPASS_EN
   // A same-cycle writeback beats the stale register-file read.
   always_comb begin
      src1_val = bus.reg1_data;
      src2_val = bus.reg2_data;
      if (bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == dec.rs1))
         src1_val = bus.wb_data;
      if (bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == dec.rs2))
         src2_val = bus.wb_data;
   end
`else
   logic unused_wb;
   assign unused_wb = ^{bus.wb_reg_write, bus.wb_rd, bus.wb_data};
   assign src1_val  = bus.reg1_data;
   assign src2_val  = bus.reg2_data;
`endif

   assign ex_valid = (state_q == ST_FULL);
   assign in_ready = !ex_valid || bus.ex_ready;
   assign capture  = bus.in_valid && in_ready && !bus.flush;

   always_comb begin
      payload_d           = '0;
      payload_d.rs1_val   = dec.use_rs1 ? src1_val : 32'd0;
      payload_d.rs2_val   = dec.use_rs2 ? src2_val : 32'd0;
      payload_d.imm       = dec.imm;
      payload_d.rd        = dec.rd;
      payload_d.alu_op    = dec.alu_op;
      payload_d.use_imm   = dec.use_imm;
      payload_d.reg_write = dec.reg_write;
      payload_d.illegal   = dec.illegal;
   end

   // Flush wins over capture; a drain with a same-cycle capture stays FULL.
   always_comb begin
      state_d = state_q;
      if (bus.flush)
         state_d = ST_EMPTY;
      else if (capture)
         state_d = ST_FULL;
      else if (bus.ex_ready)
         state_d = ST_EMPTY;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_EMPTY;
         payload_q <= '0;
      end else begin
         state_q <= state_d;
         if (capture)
            payload_q <= payload_d;
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.source_reg1  = dec.rs1;
   assign bus.source_reg2  = dec.rs2;
   assign bus.ex_valid     = ex_valid;
   assign bus.ex_rs1_val   = payload_q.rs1_val;
   assign bus.ex_rs2_val   = payload_q.rs2_val;
   assign bus.ex_imm       = payload_q.imm;
   assign bus.ex_rd        = payload_q.rd;
   assign bus.ex_alu_op    = payload_q.alu_op;
   assign bus.ex_use_imm   = payload_q.use_imm;
   assign bus.ex_reg_write = payload_q.reg_write;
   assign bus.ex_illegal   = payload_q.illegal;
   assign bus.dbg_state    = state_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port in_valid  input  1  fetched instruction valid.
REQ-004 SHALL have port in_ready  output  1  stage can accept instruction this cycle.
REQ-005 SHALL have port instr  input  32  RV32I instruction word.
REQ-006 SHALL have port source_reg1, source_reg2  output  5 each  register-file read addresses, combinational from instr.
REQ-007 SHALL have port reg1_data, reg2_data  input  32 each  register-file read data, same cycle.
REQ-008 SHALL have port flush  input  1  discard held and incoming instruction.
REQ-009 SHALL have port wb_reg_write, wb_rd, wb_data  input  1/5/32  writeback bypass source.
REQ-010 SHALL have port ex_valid  output  1  execute payload valid.
REQ-011 SHALL have port ex_ready  input  1  execute stage accepts payload.
REQ-012 SHALL have port ex_rs1_val, ex_rs2_val, ex_imm  output  32 each  operands, sign-extended immediate.
REQ-013 SHALL have port ex_rd  output  5; ex_alu_op  output  4; ex_use_imm, ex_reg_write, ex_illegal  output  1 each.

Function
REQ-014 SHALL hold one pipeline register with states EMPTY and FULL; ex_valid=1 only in FULL.
REQ-015 SHALL drive in_ready = !ex_valid | ex_ready (combinational pass-through when draining).
REQ-016 SHALL capture on in_valid & in_ready; latency instr to ex_valid = 1 cycle; EMPTY->FULL on capture, FULL->EMPTY on ex_ready without capture, FULL->FULL on simultaneous drain and capture.
REQ-017 SHALL hold all ex_* outputs stable while ex_valid & !ex_ready.
REQ-018 SHALL decode opcode 0110011 (R): alu_op={funct7[5],funct3}, use_imm=0.
REQ-019 SHALL decode opcode 0010011 (I-ALU): imm=sext(instr[31:20]), use_imm=1, alu_op={funct3==101 ? funct7[5] : 0, funct3}.
REQ-020 SHALL decode opcode 0110111 (LUI): imm={instr[31:12],12'b0}, rs1 value forced to 0, alu_op=0000, use_imm=1.
REQ-021 SHALL flag any other opcode with ex_illegal=1, ex_reg_write=0, operands zero.
REQ-022 SHALL force ex_reg_write=0 when rd=0.
REQ-023 SHALL on flush go EMPTY next cycle and not capture the same-cycle instruction; flush overrides capture.

Reset
REQ-024 SHALL on reset asynchronously enter EMPTY with all ex_* outputs 0; in_ready=1 after reset.
REQ-025 SHALL drop any held instruction on reset mid-operation; no partial payload emitted.

Configuration
REQ-026 SHALL with ID_WB_BYPASS_EN defined select wb_data for an operand when wb_reg_write=1, wb_rd!=0 and wb_rd equals that source register at capture.
REQ-027 SHALL without ID_WB_BYPASS_EN ignore wb_* inputs and use reg1_data/reg2_data directly.

Structure
REQ-028 SHALL place opcode constants, 4-bit ALU op codes and the state enum in shared package rv_pkg.
REQ-029 SHALL isolate combinational field/immediate decode in sub-module instr_decoder.

Verification
REQ-030 SHALL check: instr=0x002081B3 (ADD x3,x1,x2), reg1_data=5, reg2_data=7 -> next cycle ex_valid=1, rs1_val=5, rs2_val=7, rd=3, alu_op=0x0, reg_write=1.
REQ-031 SHALL check: instr=0xFFF00293 (ADDI x5,x0,-1) -> ex_imm=0xFFFFFFFF, use_imm=1, source_reg1=0.
REQ-032 SHALL check: instr=0x40325213 (SRAI x4,x4,3) -> alu_op=0xD, ex_imm=0x00000403; instr=0x123453B7 (LUI) -> ex_imm=0x12345000, rs1_val=0.
REQ-033 SHALL check: ex_ready=0 for 3 cycles with FULL -> in_ready=0, outputs unchanged; ex_ready=1 with in_valid=1 -> back-to-back capture, no bubble.
REQ-034 SHALL check: flush with in_valid=1 -> ex_valid=0 next cycle; reset asserted while FULL -> ex_valid=0 immediately.
REQ-035 SHALL check with ID_WB_BYPASS_EN: wb_rd=1, wb_data=0xDEADBEEF, reg1_data=5, ADD x3,x1,x2 -> rs1_val=0xDEADBEEF; wb_rd=0 -> no bypass.
